demultiplexer_sync: RTL and testbench

//  Registered 1-to-8 demultiplexer: the distributing counterpart of the 8:1 multiplexer.

---
 rtl/demultiplexer_sync.sv | 63 ++++++
 tb/tb_demultiplexer_sync.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/demultiplexer_sync.sv
// rtl/demultiplexer_sync.sv - registered 1-to-8 demultiplexer with per-channel 1-deep valid/ready holding registers
module demultiplexer_sync #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [2:0]         select,
    input  logic               in_valid,
    input  logic [WIDTH-1:0]   in_data,
    output logic               in_ready,
    output logic [7:0]         y_valid,
    output logic [8*WIDTH-1:0] y_data,
    input  logic [7:0]         y_ready,
    output logic [CNT_W-1:0]   xfer_count
);

    logic [7:0]       valid_q, valid_d;
    logic [WIDTH-1:0] data_q [8];
    logic [WIDTH-1:0] data_d [8];
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             xfer;

    always_comb begin
        // y_ready pass-through lets a draining channel take a new word in the same cycle
        in_ready = enable & ~rst & (~valid_q[select] | y_ready[select]);
        xfer     = in_valid & in_ready;
        valid_d  = valid_q & ~y_ready;
        data_d   = data_q;
        cnt_d    = cnt_q;
        if (xfer) begin
            valid_d[select] = 1'b1;
            data_d[select]  = in_data;
            cnt_d           = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            cnt_q   <= '0;
            for (int k = 0; k < 8; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    genvar g;
    generate
        for (g = 0; g < 8; g++) begin : g_out
            assign y_data[g*WIDTH +: WIDTH] = data_q[g];
        end
    endgenerate

    assign y_valid    = valid_q;
    assign xfer_count = cnt_q;

endmodule

// File: tb/tb_demultiplexer_sync.sv
// tb/tb_demultiplexer_sync.sv - scoreboard bench for demultiplexer_sync
module tb_demultiplexer_sync;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               enable;
    logic [2:0]         select;
    logic               in_valid;
    logic [WIDTH-1:0]   in_data;
    logic               in_ready;
    logic [7:0]         y_valid;
    logic [8*WIDTH-1:0] y_data;
    logic [7:0]         y_ready;
    logic [CNT_W-1:0]   xfer_count;

    demultiplexer_sync #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .select     (select),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .y_valid    (y_valid),
        .y_data     (y_data),
        .y_ready    (y_ready),
        .xfer_count (xfer_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] ch;
        logic [7:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Output side: every pop is matched against the oldest expected word for that channel
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            for (int k = 0; k < 8; k++) begin
                if (y_valid[k] && y_ready[k]) begin
                    int idx;
                    idx = -1;
                    for (int i = 0; i < exp_q.size(); i++) begin
                        if (idx < 0 && exp_q[i].ch == 3'(k)) idx = i;
                    end
                    n_vec++;
                    if (idx < 0) begin
                        n_miss++;
                        $display("FAIL pop_ch%0d: got 0x%0h expected no word", k, y_data[k*8 +: 8]);
                    end else begin
                        if (y_data[k*8 +: 8] !== exp_q[idx].d) begin
                            n_miss++;
                            $display("FAIL pop_ch%0d: got 0x%0h expected 0x%0h",
                                     k, y_data[k*8 +: 8], exp_q[idx].d);
                        end
                        exp_q.delete(idx);
                    end
                end
            end
        end
    end

    // One cycle of stimulus; state checks reflect the edge before this step's inputs take effect
    task automatic step(input string name, input logic r, input logic en, input logic [2:0] sel,
                        input logic iv, input logic [7:0] d, input logic [7:0] yr,
                        input logic exp_rdy, input bit chk_state,
                        input logic [7:0] exp_yv, input logic [3:0] exp_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; enable = en; select = sel; in_valid = iv; in_data = d; y_ready = yr;
        #1;
        chk({name, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (chk_state) begin
            chk({name, ".y_valid"}, 32'(y_valid), 32'(exp_yv));
            chk({name, ".xfer_count"}, 32'(xfer_count), 32'(exp_cnt));
        end
        if (r) exp_q.delete();
        if (exp_rdy && iv && !r) begin
            e.ch = sel;
            e.d  = d;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        rst = 1'b1; enable = 1'b1; select = 3'd0; in_valid = 1'b1; in_data = 8'h77; y_ready = 8'h00;

        step("rst0", 1, 1, 0, 1, 8'h77, 8'h00, 0, 0, 8'h00, 4'd0);
        step("rst1", 1, 1, 0, 1, 8'h77, 8'h00, 0, 1, 8'h00, 4'd0);
        mon_en = 1'b1;

        for (int k = 0; k < 8; k++) begin
            step($sformatf("route%0d", k), 0, 1, 3'(k), 1, 8'(8'h10 + k), 8'hFF, 1, 1,
                 (k == 0) ? 8'h00 : 8'(1 << (k - 1)), 4'(k));
        end
        step("route_idle", 0, 1, 0, 0, 8'h00, 8'hFF, 1, 1, 8'h80, 4'd8);

        step("bp_a", 0, 1, 3, 1, 8'hA5, 8'h00, 1, 1, 8'h00, 4'd8);
        step("bp_b", 0, 1, 3, 1, 8'h5A, 8'h00, 0, 1, 8'h08, 4'd9);
        chk("bp_b.y_data3", 32'(y_data[3*8 +: 8]), 32'hA5);
        step("bp_c", 0, 1, 3, 1, 8'h5A, 8'h00, 0, 1, 8'h08, 4'd9);
        chk("bp_c.y_data3", 32'(y_data[3*8 +: 8]), 32'hA5);
        step("bp_d", 0, 1, 3, 1, 8'h5A, 8'h08, 1, 1, 8'h08, 4'd9);
        step("bp_e", 0, 1, 6, 1, 8'hC3, 8'h00, 1, 1, 8'h08, 4'd10);
        chk("bp_e.y_data3", 32'(y_data[3*8 +: 8]), 32'h5A);

        step("dis_f", 0, 0, 6, 1, 8'h99, 8'h00, 0, 1, 8'h48, 4'd11);
        step("dis_g", 0, 0, 6, 1, 8'h99, 8'h40, 0, 1, 8'h48, 4'd11);
        chk("dis_g.y_data6", 32'(y_data[6*8 +: 8]), 32'hC3);
        step("dis_h", 0, 0, 3, 1, 8'h99, 8'h00, 0, 1, 8'h08, 4'd11);
        chk("dis_h.y_data3", 32'(y_data[3*8 +: 8]), 32'h5A);
        step("pp_i",  0, 1, 3, 1, 8'hE1, 8'h08, 1, 1, 8'h08, 4'd11);
        step("pp_j",  0, 1, 0, 0, 8'h00, 8'hFF, 1, 1, 8'h08, 4'd12);

        // Counter is 4 bits wide: 15 after 15 transfers, then 0, then 1
        step("wrap0", 0, 1, 1, 1, 8'h30, 8'hFF, 1, 1, 8'h00, 4'd12);
        step("wrap1", 0, 1, 1, 1, 8'h31, 8'hFF, 1, 1, 8'h02, 4'd13);
        step("wrap2", 0, 1, 1, 1, 8'h32, 8'hFF, 1, 1, 8'h02, 4'd14);
        step("wrap3", 0, 1, 1, 1, 8'h33, 8'hFF, 1, 1, 8'h02, 4'd15);
        step("wrap4", 0, 1, 1, 1, 8'h34, 8'hFF, 1, 1, 8'h02, 4'd0);
        step("wrap5", 0, 1, 1, 1, 8'h35, 8'hFF, 1, 1, 8'h02, 4'd1);
        step("wrap_idle", 0, 1, 0, 0, 8'h00, 8'hFF, 1, 1, 8'h02, 4'd2);

        step("mid_m", 0, 1, 2, 1, 8'hBB, 8'h00, 1, 1, 8'h00, 4'd2);
        step("mid_n", 1, 1, 2, 1, 8'hCC, 8'h00, 0, 1, 8'h04, 4'd3);
        step("mid_o", 0, 1, 0, 0, 8'h00, 8'hFF, 1, 1, 8'h00, 4'd0);
        step("mid_p", 0, 1, 0, 0, 8'h00, 8'hFF, 1, 1, 8'h00, 4'd0);
        chk("mid_p.y_data2", 32'(y_data[2*8 +: 8]), 32'h00);

        @(negedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
